seg_scan_mux: RTL and testbench

- Time-multiplexed scan driver for a multi-digit common-anode 7-segment display; sits directly upstream of the BCD-to-7-segment decoder.
- Holds NDIG BCD digits in a shadow register and cycles through them at a divided refresh rate.
- Each cycle it presents the active digit's BCD code on NUM, which the decoder turns into SEG, plus the matching active-low anode select.
- Inserts a guard (ghost-suppression) window at every digit switch and blanks invalid BCD codes.

---
 rtl/seg_scan_mux.sv | 77 +++++++
 tb/tb_seg_scan_mux.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 7-segment digit scanner with guard window and BCD blanking
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg_scan_mux #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [4*NDIG-1:0]       i_digits,
  output logic [3:0]              o_num,
  output logic [NDIG-1:0]         o_an,
  output logic                    o_blank,
  output logic [$clog2(NDIG)-1:0] o_idx
);
  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_GRD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [NDIG-1:0][3:0]   r_shadow;
  logic [3:0]             r_num;
  logic [NDIG-1:0]        r_an;
  logic                   r_blank;
  logic                   w_wrap;
  logic [CW-1:0]          w_cnt_nxt;
  logic [IW-1:0]          w_idx_nxt;
  logic [NDIG-1:0][3:0]   w_shadow_nxt;
  logic [3:0]             w_dig_nxt;
  logic                   w_sup_nxt;
  logic                   w_blank_nxt;
  logic [NDIG-1:0]        w_an_nxt;
  assign w_wrap       = r_cnt == CNT_MAX;
  assign w_cnt_nxt    = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt    = !w_wrap ? r_idx : (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
  assign w_shadow_nxt = i_load ? i_digits : r_shadow;
  assign w_dig_nxt    = w_shadow_nxt[w_idx_nxt];
`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] w_zero_up;
  // w_zero_up[k] is set when digit k and every digit above it are zero
  always_comb begin
    w_zero_up = '0;
    w_zero_up[NDIG-1] = w_shadow_nxt[NDIG-1] == 4'd0;
    for (int k = NDIG - 2; k >= 0; k--)
      w_zero_up[k] = w_zero_up[k+1] && (w_shadow_nxt[k] == 4'd0);
  end
  assign w_sup_nxt = (w_idx_nxt != '0) && w_zero_up[w_idx_nxt];
`else
  assign w_sup_nxt = 1'b0;
`endif
  assign w_blank_nxt = (w_cnt_nxt < CNT_GRD) || (w_dig_nxt > 4'd9) || w_sup_nxt;
  assign w_an_nxt    = w_blank_nxt ? '1 : ~(NDIG'(1) << w_idx_nxt);
  // Scan state and outputs all register the next-state view so outputs never lag the scan
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_num    <= '0;
      r_an     <= '1;
      r_blank  <= 1'b1;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      r_num    <= w_dig_nxt;
      r_an     <= w_an_nxt;
      r_blank  <= w_blank_nxt;
    end
  assign o_num   = r_num;
  assign o_an    = r_an;
  assign o_blank = r_blank;
  assign o_idx   = r_idx;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: table vectors, corner sequences and random scan checked against a time-based model
module tb_seg_scan_mux;
  localparam int NDIG = 4, DIV = 8, GUARD = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_load = 1'b0;
  logic [15:0] i_digits = '0;
  logic [3:0]  o_num;
  logic [3:0]  o_an;
  logic        o_blank;
  logic [1:0]  o_idx;
  int          n_vec = 0, n_bad = 0, t = 0;
  logic [15:0] sh = '0;
  typedef struct {
    logic [15:0] dg;
    int          t;
    logic [3:0]  num;
    logic [3:0]  an;
    logic        blank;
  } vec_t;
  vec_t tbl[15];

  seg_scan_mux #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(i_load), .i_digits(i_digits),
    .o_num(o_num), .o_an(o_an), .o_blank(o_blank), .o_idx(o_idx)
  );

  always #5 clk = ~clk;

  // Expected outputs t edges after reset release, from the display rules alone
  function automatic logic [10:0] model(input int tt, input logic [15:0] s);
    int         cnt = tt % DIV;
    int         slot = (tt / DIV) % NDIG;
    logic [3:0] d = s[slot*4 +: 4];
    logic       sup = LZB && slot > 0 && (s >> (4 * slot)) == 16'd0;
    logic       blank = cnt < GUARD || d > 4'd9 || sup;
    logic [3:0] an = blank ? 4'hF : ~(4'b0001 << slot);
    return {d, an, blank, 2'(slot)};
  endfunction

  function automatic logic [10:0] outs();
    return {o_num, o_an, o_blank, o_idx};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got num=%h an=%b blank=%b idx=%0d want num=%h an=%b blank=%b idx=%0d",
               name, t, act[10:7], act[6:3], act[2], act[1:0], exp[10:7], exp[6:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    sh = '0;
  endtask

  task automatic step(input logic ld, input logic [15:0] dg);
    i_load = ld;
    i_digits = dg;
    @(posedge clk);
    t++;
    if (ld) sh = dg;
    #1;
    i_load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 16'h0);
      chk("scan", outs(), model(t, sh));
    end
  endtask

  initial begin
    tbl[0]  = '{16'h1234, 4,  4'h4, 4'hE, 1'b0};
    tbl[1]  = '{16'h1234, 12, 4'h3, 4'hD, 1'b0};
    tbl[2]  = '{16'h1234, 20, 4'h2, 4'hB, 1'b0};
    tbl[3]  = '{16'h1234, 28, 4'h1, 4'h7, 1'b0};
    tbl[4]  = '{16'h1234, 9,  4'h3, 4'hF, 1'b1};
    tbl[5]  = '{16'h9A05, 4,  4'h5, 4'hE, 1'b0};
    tbl[6]  = '{16'h9A05, 12, 4'h0, 4'hD, 1'b0};
    tbl[7]  = '{16'h9A05, 20, 4'hA, 4'hF, 1'b1};
    tbl[8]  = '{16'h9A05, 28, 4'h9, 4'h7, 1'b0};
    tbl[9]  = '{16'h0070, 28, 4'h0, LZB ? 4'hF : 4'h7, LZB};
    tbl[10] = '{16'h0070, 20, 4'h0, LZB ? 4'hF : 4'hB, LZB};
    tbl[11] = '{16'h0070, 12, 4'h7, 4'hD, 1'b0};
    tbl[12] = '{16'h0070, 4,  4'h0, 4'hE, 1'b0};
    tbl[13] = '{16'h0000, 12, 4'h0, LZB ? 4'hF : 4'hD, LZB};
    tbl[14] = '{16'h0000, 4,  4'h0, 4'hE, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_state", outs(), {4'h0, 4'hF, 1'b1, 2'd0});
    rst_n = 1'b1;
    t = 0;
    sh = '0;
    chk("release", outs(), model(0, sh));
    run(34);

    for (int k = 0; k < 15; k++) begin
      do_reset();
      step(1'b1, tbl[k].dg);
      while (t < tbl[k].t) step(1'b0, 16'h0);
      chk($sformatf("tbl%0d", k), {o_num, o_an, o_blank, o_idx},
          {tbl[k].num, tbl[k].an, tbl[k].blank, 2'((tbl[k].t / DIV) % NDIG)});
    end

    do_reset();
    step(1'b1, 16'h1234);
    chk("scan", outs(), model(t, sh));
    run(30);
    step(1'b1, 16'h8888);
    chk("wrap_load", outs(), {4'h8, 4'hF, 1'b1, 2'd0});
    chk("scan", outs(), model(t, sh));
    run(10);

    do_reset();
    step(1'b1, 16'h5678);
    run(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", outs(), {4'h0, 4'hF, 1'b1, 2'd0});
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    sh = '0;
    run(36);

    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic        ld;
      logic [15:0] dg, mask;
      ld = $urandom_range(0, 7) == 0;
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h0FFF;
        2: mask = 16'h00FF;
        default: mask = 16'h000F;
      endcase
      dg = 16'($urandom) & mask;
      step(ld, dg);
      chk("rand", outs(), model(t, sh));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
